// File: rtl/qam_word_feeder.sv
// Word feeder for the QAM modulator: FIFO-buffered payload, one word presented per dbufempt rise.
// Optional payload whitening with a 32-bit Galois LFSR when QAM_FEEDER_SCRAMBLE_EN is defined.
module qam_word_feeder #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          i_dclk,
  input  logic          i_rstn,
  input  logic [31:0]   i_wr_data,
  input  logic          i_wr_valid,
  output logic          o_wr_ready,
  input  logic          i_dbufempt,
  output logic [31:0]   o_data,
  output logic          o_data_vld,
  output logic [AW:0]   o_level,
  output logic          o_underrun
);

  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] LevelFull = LW'(DEPTH);

  typedef enum logic [0:0] {StEmpty, StLoaded} state_e;

  state_e        r_state;
  state_e        w_state_d;
  logic          r_dbufempt_q;
  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic [31:0]   r_data;
  logic          r_underrun;

  logic          w_adv;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_clear;
  logic [31:0]   w_head;
  logic [31:0]   w_load_word;

  assign w_adv      = i_dbufempt & ~r_dbufempt_q;
  assign w_empty    = (r_level == '0);
  assign o_wr_ready = (r_level != LevelFull);
  assign w_push     = i_wr_valid & o_wr_ready;
  assign w_head     = r_mem[r_rptr];

`ifdef QAM_FEEDER_SCRAMBLE_EN
  localparam logic [31:0] LfsrPoly = 32'h04C1_1DB7;
  logic [31:0] r_lfsr;

  // The LFSR steps only on real loads, so the underrun zero word leaves it untouched.
  always_ff @(posedge i_dclk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_lfsr <= 32'hFFFF_FFFF;
    end else if (w_pop) begin
      r_lfsr <= {r_lfsr[30:0], 1'b0} ^ (r_lfsr[31] ? LfsrPoly : 32'h0);
    end
  end

  assign w_load_word = w_head ^ r_lfsr;
`else
  assign w_load_word = w_head;
`endif

  // FSM state register
  always_ff @(posedge i_dclk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= StEmpty;
    end else begin
      r_state <= w_state_d;
    end
  end

  // FSM next state
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StEmpty:  if (!w_empty)          w_state_d = StLoaded;
      StLoaded: if (w_adv && w_empty)  w_state_d = StEmpty;
      default:                         w_state_d = StEmpty;
    endcase
  end

  // FSM outputs; EMPTY loads from the registered level regardless of adv
  always_comb begin
    w_pop      = 1'b0;
    w_clear    = 1'b0;
    o_data_vld = 1'b0;
    unique case (r_state)
      StEmpty: begin
        w_pop = ~w_empty;
      end
      StLoaded: begin
        o_data_vld = 1'b1;
        w_pop      = w_adv & ~w_empty;
        w_clear    = w_adv & w_empty;
      end
      default: ;
    endcase
  end

  // FIFO storage carries no reset; pointers alone define validity
  always_ff @(posedge i_dclk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_dclk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_dbufempt_q <= 1'b0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_level      <= '0;
      r_data       <= '0;
      r_underrun   <= 1'b0;
    end else begin
      r_dbufempt_q <= i_dbufempt;
      r_underrun   <= w_adv & w_empty;
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
        r_data <= w_load_word;
      end else if (w_clear) begin
        r_data <= '0;
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LW'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - LW'(1);
      end
    end
  end

  assign o_data     = r_data;
  assign o_level    = r_level;
  assign o_underrun = r_underrun;

endmodule

// File: tb/tb_qam_word_feeder.sv
// Directed and randomized bench for qam_word_feeder against a queue-based reference model.
module tb_qam_word_feeder;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic [31:0]   wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic          dbufempt = 1'b0;
  logic [31:0]   data;
  logic          data_vld;
  logic [AW:0]   level;
  logic          underrun;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_q [$];
  logic [31:0] m_data;
  logic        m_vld;
  logic        m_underrun;
  logic        m_prev_db;
  logic [31:0] m_lfsr;

  always #5 clk = ~clk;

  qam_word_feeder #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_dut (
    .i_dclk     (clk),
    .i_rstn     (rstn),
    .i_wr_data  (wr_data),
    .i_wr_valid (wr_valid),
    .o_wr_ready (wr_ready),
    .i_dbufempt (dbufempt),
    .o_data     (data),
    .o_data_vld (data_vld),
    .o_level    (level),
    .o_underrun (underrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    m_data     = '0;
    m_vld      = 1'b0;
    m_underrun = 1'b0;
    m_prev_db  = 1'b0;
    m_lfsr     = 32'hFFFF_FFFF;
  endtask

  task automatic m_take(output logic [31:0] w);
    w = m_q.pop_front();
`ifdef QAM_FEEDER_SCRAMBLE_EN
    w      = w ^ m_lfsr;
    m_lfsr = {m_lfsr[30:0], 1'b0} ^ (m_lfsr[31] ? 32'h04C1_1DB7 : 32'h0);
`endif
  endtask

  task automatic chk_outputs();
    chk("data", data, m_data);
    chk("data_vld", 32'(data_vld), 32'(m_vld));
    chk("level", 32'(level), 32'(m_q.size()));
    chk("underrun", 32'(underrun), 32'(m_underrun));
  endtask

  // One clock: drive at negedge, advance model, check #1 after posedge.
  task automatic step(input logic wv, input logic [31:0] wd, input logic db);
    int          n;
    logic        adv;
    logic [31:0] w;
    @(negedge clk);
    wr_valid = wv;
    wr_data  = wd;
    dbufempt = db;
    n = m_q.size();
    chk("wr_ready", 32'(wr_ready), 32'(n < DEPTH));
    adv        = db && !m_prev_db;
    m_underrun = 1'b0;
    if (!m_vld) begin
      if (n > 0) begin
        m_take(w);
        m_data = w;
        m_vld  = 1'b1;
      end else if (adv) begin
        m_underrun = 1'b1;
      end
    end else if (adv) begin
      if (n > 0) begin
        m_take(w);
        m_data = w;
      end else begin
        m_data     = '0;
        m_vld      = 1'b0;
        m_underrun = 1'b1;
      end
    end
    if (wv && n < DEPTH) m_q.push_back(wd);
    m_prev_db = db;
    @(posedge clk);
    #1;
    chk_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn     = 1'b0;
    wr_valid = 1'b0;
    dbufempt = 1'b0;
    #1;
    m_reset();
    chk("rst_data", data, 32'h0);
    chk("rst_vld", 32'(data_vld), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_underrun", 32'(underrun), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    m_reset();

    // Single word latency
    do_reset();
    step(1'b1, 32'hA5A5_0001, 1'b0);
    chk("t1_level1", 32'(level), 32'd1);
    chk("t1_vld0", 32'(data_vld), 32'd0);
    step(1'b0, 32'h0, 1'b0);
    chk("t1_vld1", 32'(data_vld), 32'd1);
    chk("t1_level0", 32'(level), 32'd0);
`ifdef QAM_FEEDER_SCRAMBLE_EN
    chk("t1_data", data, 32'h5A5A_FFFE);
`else
    chk("t1_data", data, 32'hA5A5_0001);
`endif

    // Fill to full; a held push waits
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, $urandom, 1'b0);
    chk("t2_level7", 32'(level), 32'd7);
    step(1'b1, $urandom, 1'b0);
    step(1'b1, $urandom, 1'b0);
    chk("t2_level8", 32'(level), 32'd8);
    chk("t2_ready0", 32'(wr_ready), 32'd0);
    step(1'b1, 32'hDEAD_0010, 1'b0);
    chk("t2_held", 32'(level), 32'd8);

    // Adv with push on a full FIFO: pop only, push lands next cycle
    step(1'b1, 32'hDEAD_0010, 1'b1);
    chk("t5_level7", 32'(level), 32'd7);
    step(1'b1, 32'hDEAD_0010, 1'b1);
    chk("t5_level8", 32'(level), 32'd8);

    // dbufempt held high five cycles gives one advance
    step(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);
    chk("t3_one_adv", 32'(level), 32'd7);

    // Drain, then underrun
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 32'h0, 1'b0);
      step(1'b0, 32'h0, 1'b1);
    end
    chk("t4_drained", 32'(level), 32'd0);
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    chk("t4_underrun", 32'(underrun), 32'd1);
    chk("t4_data0", data, 32'h0);
    chk("t4_vld0", 32'(data_vld), 32'd0);
    step(1'b0, 32'h0, 1'b1);
    chk("t4_pulse", 32'(underrun), 32'd0);
    step(1'b1, 32'h5A5A_1234, 1'b0);
    chk("t4_notyet", 32'(data_vld), 32'd0);
    step(1'b0, 32'h0, 1'b0);
    chk("t4_reload", 32'(data_vld), 32'd1);

    // Reset mid-stream
    for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0);
    chk("t6_level4", 32'(level), 32'd4);
    do_reset();
    step(1'b0, 32'h0, 1'b0);
    chk("t6_empty", 32'(level), 32'd0);

    // Random traffic: write-heavy then read-heavy
    for (int i = 0; i < 400; i++) begin
      logic wv;
      logic db;
      wv = ($urandom_range(0, 9) < ((i < 200) ? 8 : 3));
      db = ($urandom_range(0, 2) == 0);
      step(wv, $urandom, db);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
